// File: rtl/uni_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
package uni_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_LOAD = 3'b001,
      OP_SHL  = 3'b010,
      OP_SHR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101,
      OP_ASR  = 3'b110,
      OP_CLR  = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Ops whose step count comes from the amt port (the rest use a fixed count).
   function automatic logic op_uses_amt(op_e op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/uni_shift_reg_if.sv
// Command/status bundle between a requester (master) and the shift register (slave).
interface uni_shift_reg_if #(
   parameter int WIDTH = 4,
   parameter int AMT_W = $clog2(WIDTH) + 1
);
   import uni_pkg::*;

   // Handshake: start is sampled only while busy=0; a sampled start captures
   // op/amt/d/sin and raises busy on the next cycle. busy stays high until
   // the command finishes, then done pulses for exactly one cycle, during
   // which busy=0 and a new start is accepted. start while busy is dropped.
   logic             start;
   op_e              op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] d;
   logic             sin;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             busy;
   logic             done;

   modport master (
      output start, op, amt, d, sin,
      input  q, sout, busy, done
   );

   modport slave (
      input  start, op, amt, d, sin,
      output q, sout, busy, done
   );

endinterface

// File: rtl/uni_shift_step.sv
// One combinational step of the shift register: the next q and the bit leaving it.
module uni_shift_step
   import uni_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  op_e              op,
   input  logic             sin,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_next,
   output logic             bit_out
);

   always_comb begin
      q_next  = q;
      bit_out = 1'b0;
      case (op)
         OP_LOAD: q_next = d;
         OP_CLR:  q_next = '0;
         OP_SHL: begin
            q_next  = {q[WIDTH-2:0], sin};
            bit_out = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next  = {sin, q[WIDTH-1:1]};
            bit_out = q[0];
         end
         OP_ROL: begin
            q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
            bit_out = q[WIDTH-1];
         end
         OP_ROR: begin
            q_next  = {q[0], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         OP_ASR: begin
            q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
            bit_out = q[0];
         end
         default: begin
            q_next  = q;
            bit_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/uni_shift_reg.sv
// Universal shift register: accepts one command, applies its steps one per
// clock, then pulses done. State is exposed on dbg_state.
module uni_shift_reg
   import uni_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   uni_shift_reg_if.slave  bus,
   output state_e          dbg_state
);

   localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic             sin_q, sin_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_q;
   logic             step_bit;

   // Number of steps a command takes; shift amounts saturate at WIDTH.
   function automatic logic [AMT_W-1:0] cmd_count(op_e op, logic [AMT_W-1:0] amt);
      if (op_uses_amt(op)) return (amt > AMT_MAX) ? AMT_MAX : amt;
      if (op == OP_HOLD)   return '0;
      return AMT_W'(1);
   endfunction

   uni_shift_step #(.WIDTH(WIDTH)) u_step (
      .q       (q_q),
      .op      (op_q),
      .sin     (sin_q),
      .d       (d_q),
      .q_next  (step_q),
      .bit_out (step_bit)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sin_d   = sin_q;
      d_d     = d_q;
      count_d = count_q;
      q_d     = q_q;
      sout_d  = sout_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               sin_d   = bus.sin;
               d_d     = bus.d;
               count_d = cmd_count(bus.op, bus.amt);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (count_q != '0) begin
               q_d     = step_q;
               sout_d  = step_bit;
               count_d = count_q - AMT_W'(1);
            end
            // A zero-count command still spends one RUN cycle before finishing.
            if (count_q <= AMT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_HOLD;
         sin_q   <= 1'b0;
         d_q     <= '0;
         count_q <= '0;
         q_q     <= '0;
         sout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sin_q   <= sin_d;
         d_q     <= d_d;
         count_q <= count_d;
         q_q     <= q_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
      end
   end

   assign bus.q     = q_q;
   assign bus.sout  = sout_q;
   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uni_shift_reg.sv
// Bench for uni_shift_reg at WIDTH=4: directed table, corner sequences, random vs model.
module tb_uni_shift_reg;
   import uni_pkg::*;

   localparam int W  = 4;
   localparam int AW = $clog2(W) + 1;

   logic   clk;
   logic   rst_n;
   state_e dbg_state;

   uni_shift_reg_if #(.WIDTH(W), .AMT_W(AW)) bus ();

   uni_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: whole-command result from plain arithmetic on the original q.
   function automatic void model_cmd(input op_e op, input int amt, input logic s,
                                     input logic [W-1:0] dd, inout logic [W-1:0] mq,
                                     inout logic mso, output int busy_n);
      int n;
      logic signed [W-1:0] t;
      case (op)
         OP_HOLD:          n = 0;
         OP_LOAD, OP_CLR:  n = 1;
         default:          n = (amt > W) ? W : amt;
      endcase
      busy_n = (n == 0) ? 1 : n;
      case (op)
         OP_LOAD: begin mq = dd; mso = 1'b0; end
         OP_CLR:  begin mq = '0; mso = 1'b0; end
         OP_SHL: begin
            if (n > 0) mso = mq[W-n];
            mq = W'((32'(mq) << n) | (s ? ((1 << n) - 1) : 0));
         end
         OP_SHR: begin
            if (n > 0) mso = mq[n-1];
            mq = W'((32'(mq) >> n) | (s ? (((1 << n) - 1) << (W - n)) : 0));
         end
         OP_ROL: begin
            if (n > 0) mso = mq[W-n];
            mq = W'((32'(mq) << n) | (32'(mq) >> (W - n)));
         end
         OP_ROR: begin
            if (n > 0) mso = mq[n-1];
            mq = W'((32'(mq) >> n) | (32'(mq) << (W - n)));
         end
         OP_ASR: begin
            if (n > 0) mso = mq[n-1];
            t  = $signed(mq);
            t  = t >>> n;
            mq = t;
         end
         default: ;
      endcase
   endfunction

   // Issue one command, follow it to done, and check result and timing.
   task automatic run_cmd(input op_e op, input logic [AW-1:0] amt, input logic [W-1:0] dd,
                          input logic s, input logic [W-1:0] exp_q, input logic exp_sout,
                          input int exp_busy, input logic scramble);
      logic [W-1:0] q_before;
      int busy_cnt;
      int guard;
      q_before = bus.q;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.amt   = amt;
      bus.d     = dd;
      bus.sin   = s;
      @(negedge clk);
      bus.start = 1'b0;
      check("q_held_on_accept", bus.q, q_before);
      check("busy_after_accept", bus.busy, 1'b1);
      busy_cnt = 0;
      guard    = 0;
      while (!bus.done && guard < 20) begin
         if (bus.busy) busy_cnt++;
         if (scramble) begin
            bus.op  = op_e'($urandom_range(0, 7));
            bus.amt = AW'($urandom_range(0, 7));
            bus.d   = W'($urandom_range(0, 15));
            bus.sin = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done, expected done within 20 cycles");
      end
      check("q_result", bus.q, exp_q);
      check("sout_result", bus.sout, exp_sout);
      check("busy_cycles", busy_cnt, exp_busy);
      check("busy_in_done_cycle", bus.busy, 1'b0);
      @(negedge clk);
      check("done_one_cycle", bus.done, 1'b0);
   endtask

   typedef struct {
      op_e          op;
      logic [AW-1:0] amt;
      logic [W-1:0] d;
      logic         sin;
      logic [W-1:0] exp_q;
      logic         exp_sout;
      int           exp_busy;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic [W-1:0] mq;
      logic         mso;
      int           busy_n;
      int           busy_cnt;
      int           guard;
      logic         done_seen;
      op_e          rop;
      logic [AW-1:0] ramt;
      logic [W-1:0] rd;
      logic         rs;

      tbl[0]  = '{OP_LOAD, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 1};
      tbl[1]  = '{OP_ROL,  3'd1, 4'b0000, 1'b0, 4'b0111, 1'b1, 1};
      tbl[2]  = '{OP_ROR,  3'd4, 4'b0000, 1'b0, 4'b0111, 1'b0, 4};
      tbl[3]  = '{OP_LOAD, 3'd0, 4'b1000, 1'b0, 4'b1000, 1'b0, 1};
      tbl[4]  = '{OP_ASR,  3'd2, 4'b0000, 1'b0, 4'b1110, 1'b0, 2};
      tbl[5]  = '{OP_SHR,  3'd7, 4'b0000, 1'b0, 4'b0000, 1'b1, 4};
      tbl[6]  = '{OP_HOLD, 3'd5, 4'b1111, 1'b1, 4'b0000, 1'b1, 1};
      tbl[7]  = '{OP_LOAD, 3'd0, 4'b0110, 1'b0, 4'b0110, 1'b0, 1};
      tbl[8]  = '{OP_SHL,  3'd0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1};
      tbl[9]  = '{OP_SHL,  3'd4, 4'b0000, 1'b1, 4'b1111, 1'b0, 4};
      tbl[10] = '{OP_LOAD, 3'd0, 4'b1001, 1'b0, 4'b1001, 1'b0, 1};
      tbl[11] = '{OP_ROL,  3'd5, 4'b0000, 1'b0, 4'b1001, 1'b1, 4};
      tbl[12] = '{OP_CLR,  3'd3, 4'b1111, 1'b1, 4'b0000, 1'b0, 1};
      tbl[13] = '{OP_SHR,  3'd3, 4'b0000, 1'b1, 4'b1110, 1'b0, 3};
      tbl[14] = '{OP_ROR,  3'd2, 4'b0000, 1'b0, 4'b1011, 1'b1, 2};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = OP_HOLD;
      bus.amt   = '0;
      bus.d     = '0;
      bus.sin   = 1'b0;
      #1;
      check("reset_q", bus.q, 0);
      check("reset_sout", bus.sout, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_state", dbg_state, ST_IDLE);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++)
         run_cmd(tbl[i].op, tbl[i].amt, tbl[i].d, tbl[i].sin,
                 tbl[i].exp_q, tbl[i].exp_sout, tbl[i].exp_busy, 1'b1);

      // Start while busy is dropped; start in the done cycle is taken.
      run_cmd(OP_LOAD, 3'd0, 4'b0001, 1'b0, 4'b0001, 1'b0, 1, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_SHL;
      bus.amt   = 3'd3;
      bus.sin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      busy_cnt  = 0;
      guard     = 0;
      while (!bus.done && guard < 20) begin
         if (bus.busy) busy_cnt++;
         if (busy_cnt == 2) begin
            bus.start = 1'b1;
            bus.op    = OP_LOAD;
            bus.d     = 4'b1111;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      check("b2b_done_seen", bus.done, 1'b1);
      check("ignored_start_q", bus.q, 4'b1000);
      check("ignored_start_busy_cycles", busy_cnt, 3);
      bus.start = 1'b1;
      bus.op    = OP_LOAD;
      bus.d     = 4'b0101;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_accepted_busy", bus.busy, 1'b1);
      check("b2b_q_held", bus.q, 4'b1000);
      @(negedge clk);
      check("b2b_done", bus.done, 1'b1);
      check("b2b_q", bus.q, 4'b0101);

      // Asynchronous reset in the middle of a 4-step shift.
      run_cmd(OP_LOAD, 3'd0, 4'b1010, 1'b0, 4'b1010, 1'b0, 1, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_SHL;
      bus.amt   = 3'd4;
      bus.sin   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_reset_q_after_2_steps", bus.q, 4'b1000);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_reset_q", bus.q, 0);
      check("mid_reset_busy", bus.busy, 0);
      check("mid_reset_sout", bus.sout, 0);
      check("mid_reset_state", dbg_state, ST_IDLE);
      done_seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done) done_seen = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done) done_seen = 1'b1;
      end
      check("no_done_after_abort", done_seen, 1'b0);
      run_cmd(OP_LOAD, 3'd0, 4'b0101, 1'b0, 4'b0101, 1'b0, 1, 1'b0);

      // Random commands against the reference model.
      mq  = bus.q;
      mso = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rop  = op_e'($urandom_range(0, 7));
         ramt = AW'($urandom_range(0, 7));
         rd   = W'($urandom_range(0, 15));
         rs   = 1'($urandom_range(0, 1));
         model_cmd(rop, int'(ramt), rs, rd, mq, mso, busy_n);
         run_cmd(rop, ramt, rd, rs, mq, mso, busy_n, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/uni_shift_reg.md
UNI_SHIFT_REG -- requirements
Module: uni_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 4, data register width (>=2).
REQ-002 Parameter: AMT_W, default $clog2(WIDTH)+1, width of shift-amount port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  command request; sampled only when busy=0.
REQ-006 op  input  3  operation: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR.
REQ-007 amt  input  AMT_W  shift/rotate count for ops 010-110.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin  input  1  serial fill bit for SHL (into LSB) and SHR (into MSB).
REQ-010 q  output  WIDTH  register contents.
REQ-011 sout  output  1  bit shifted/rotated out on the most recent step.
REQ-012 busy  output  1  command in progress.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE and RUN; busy=1 exactly when state=RUN.
REQ-015 On an edge with state=IDLE and start=1, the block SHALL capture op, sin, d and count, then enter RUN; q SHALL NOT change on that edge.
REQ-016 Captured count SHALL be: min(amt, WIDTH) for ops 010-110; 1 for LOAD and CLR; 0 for HOLD.
REQ-017 In RUN with count>0, each edge SHALL apply one step to q and decrement count.
REQ-018 Steps SHALL be: LOAD q=d; CLR q=0; SHL q={q[W-2:0],sin}; SHR q={sin,q[W-1:1]}; ROL q={q[W-2:0],q[W-1]}; ROR q={q[0],q[W-1:1]}; ASR q={q[W-1],q[W-1:1]}.
REQ-019 sout SHALL update on each step: q[W-1] before the step for SHL/ROL; q[0] before the step for SHR/ROR/ASR; 0 for LOAD/CLR.
REQ-020 On the edge that makes count 0, or the first RUN edge when count is already 0, the block SHALL return to IDLE and assert done for exactly the following cycle.
REQ-021 Latency: a command accepted at edge k with count N>=1 SHALL perform steps at edges k+1..k+N, with done high in the cycle after edge k+N. With N=0, q SHALL be unchanged and done SHALL be high in the cycle after edge k+1.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 start during the done cycle SHALL be accepted, allowing back-to-back commands with no idle gap.
REQ-024 Changes to op, amt, d or sin while busy SHALL NOT affect the running command.
REQ-025 amt > WIDTH SHALL saturate to WIDTH. SHL/SHR by WIDTH SHALL fill q entirely with sin; ROL/ROR by WIDTH SHALL restore the original q.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force: q=0, sout=0, busy=0, done=0, state=IDLE, count=0, captured op=HOLD.
REQ-027 Reset during RUN SHALL abort the command with no done pulse; the first start after deassertion SHALL be accepted normally.

Structure
REQ-028 Package uni_pkg SHALL hold the op encoding enum (OP_HOLD..OP_CLR) and the state enum (ST_IDLE, ST_RUN).
REQ-029 The one-step combinational transform SHALL be the sub-module uni_shift_step (inputs q, op, sin, d; outputs q_next, bit_out), parametrised by WIDTH.
REQ-030 The top module SHALL contain only the FSM, the counter and the registers.

Verification (WIDTH=4)
REQ-031 LOAD d=1011 -> q=1011 one edge after acceptance, sout=0, done pulses once.
REQ-032 q=1011, ROL amt=1 -> q=0111, sout=1. Then ROR amt=4 -> q=0111 after 4 steps, busy high for 4 cycles.
REQ-033 q=1000, ASR amt=2 -> q=1110, sout=0. Then SHR sin=0 amt=7 (saturates to 4) -> q=0000 after 4 steps.
REQ-034 During SHL amt=3, pulse start with op=LOAD -> ignored; q follows 3 shifts only. A new start in the done cycle is accepted on the next edge.
REQ-035 Assert rst_n=0 mid-SHL (after step 2 of 4), asynchronously to clk -> q=0 and busy=0 immediately, no done. After release, LOAD 0101 -> q=0101.
REQ-036 HOLD, and SHL amt=0 -> q unchanged, done in the cycle after acceptance+1.
